// File: rtl/vertex_issue_ctrl.sv
// vertex_issue_ctrl: issues RS slice indices for a fired batch, drains the PE pipeline, then pulses complete (VTX_ISSUE_PERF_EN adds perf counters)
module vertex_issue_ctrl #(
  parameter int MAX_FV_NUM  = 16,
  parameter int MULT_PER_PE = 4,
  parameter int PE_LAT      = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          fire,
  input  logic [$clog2(MAX_FV_NUM):0]   fv_len,
  input  logic                          pe_ready,
  output logic [$clog2(MAX_FV_NUM)-1:0] start_idx,
  output logic                          pe_valid,
  output logic                          complete,
  output logic                          busy,
  output logic [15:0]                   batch_cnt,
  output logic                          err_fire_busy
`ifdef VTX_ISSUE_PERF_EN
  ,
  output logic [31:0]                   perf_busy_cyc,
  output logic [31:0]                   perf_stall_cyc
`endif
);
  localparam int IW = $clog2(MAX_FV_NUM);
  localparam int LW = IW + 1;
  localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t r_state, w_state_nxt;
  logic [LW-1:0] r_len, w_len_nxt, w_len_clamp;
  logic [IW-1:0] r_idx, w_idx_nxt;
  logic [DW-1:0] r_drain, w_drain_nxt;
  logic [15:0] r_batch_cnt;
  logic r_pe_valid, r_err, w_issue, w_last;
  // next-state and datapath updates; last-slice test is one bit wider than the index so it cannot wrap
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt = r_len;
    w_idx_nxt = r_idx;
    w_drain_nxt = r_drain;
    w_len_clamp = (fv_len > LW'(MAX_FV_NUM)) ? LW'(MAX_FV_NUM) : fv_len;
    w_issue = (r_state == ISSUE) && pe_ready;
    w_last = ({1'b0, r_idx} + LW'(MULT_PER_PE)) >= r_len;
    case (r_state)
      IDLE: if (fire) begin
        w_len_nxt = w_len_clamp;
        w_idx_nxt = '0;
        w_state_nxt = (w_len_clamp == '0) ? DONE : ISSUE;
      end
      ISSUE: if (w_issue) begin
        w_idx_nxt = w_last ? '0 : r_idx + IW'(MULT_PER_PE);
        w_state_nxt = w_last ? DRAIN : ISSUE;
        w_drain_nxt = w_last ? DW'(PE_LAT - 1) : r_drain;
      end
      DRAIN: begin
        w_drain_nxt = (r_drain != '0) ? r_drain - 1'b1 : r_drain;
        w_state_nxt = (r_drain != '0) ? DRAIN : DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // state and datapath registers; pe_valid is the issue strobe delayed to line up with the RS output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_len <= '0;
      r_idx <= '0;
      r_drain <= '0;
      r_pe_valid <= 1'b0;
      r_batch_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_len <= w_len_nxt;
      r_idx <= w_idx_nxt;
      r_drain <= w_drain_nxt;
      r_pe_valid <= w_issue;
      r_batch_cnt <= (r_state == DONE) ? r_batch_cnt + 16'd1 : r_batch_cnt;
      r_err <= r_err | (fire && (r_state != IDLE));
    end
  end
  assign start_idx = r_idx;
  assign pe_valid = r_pe_valid;
  assign complete = (r_state == DONE);
  assign busy = (r_state != IDLE);
  assign batch_cnt = r_batch_cnt;
  assign err_fire_busy = r_err;
`ifdef VTX_ISSUE_PERF_EN
  logic [31:0] r_perf_busy, r_perf_stall;
  // saturating occupancy and back-pressure counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_busy <= '0;
      r_perf_stall <= '0;
    end else begin
      r_perf_busy <= (busy && !(&r_perf_busy)) ? r_perf_busy + 32'd1 : r_perf_busy;
      r_perf_stall <= ((r_state == ISSUE) && !pe_ready && !(&r_perf_stall)) ? r_perf_stall + 32'd1 : r_perf_stall;
    end
  end
  assign perf_busy_cyc = r_perf_busy;
  assign perf_stall_cyc = r_perf_stall;
`endif
endmodule
